// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one round per clock, external round-key store.
// Optional round trace ports: define AES_INV_ROUND_TRACE_EN.
module aes_inv_cipher_core #(
   parameter int NR       = 10,
   parameter int RK_IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_data,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [127:0]        rk_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data,
   output logic                busy
`ifdef AES_INV_ROUND_TRACE_EN
   ,
   output logic                dbg_valid,
   output logic [3:0]          dbg_rnd,
   output logic [127:0]        dbg_state
`endif
);

   localparam logic [RK_IDX_W-1:0] LAST  = RK_IDX_W'(NR);
   localparam logic [RK_IDX_W-1:0] FIRST = RK_IDX_W'(NR - 1);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t              state, state_nxt;
   logic [127:0]        st, st_nxt;
   logic [RK_IDX_W-1:0] rnd, rnd_nxt;
   logic [127:0]        isr, isb, ark, imc;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 by square-and-multiply; 0 maps to 0 naturally
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      logic [7:0] y;
      for (int i = 0; i < 8; i++)
         y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
      return y ^ 8'h05;
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[8*i +: 8] = gf_inv(inv_affine(s[8*i +: 8]));
      return o;
   endfunction

   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c + r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c + 8 +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         o[32*c +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                      ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[32*c + 8 +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                          ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                           ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                           ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   assign isr = inv_shift(st);
   assign isb = inv_sub(isr);
   assign ark = isb ^ rk_data;
   assign imc = inv_mix(ark);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         st    <= '0;
         rnd   <= '0;
      end else begin
         state <= state_nxt;
         st    <= st_nxt;
         rnd   <= rnd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      st_nxt    = st;
      rnd_nxt   = rnd;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = '0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            rk_idx   = LAST;
            if (in_valid) begin
               st_nxt    = in_data ^ rk_data;
               rnd_nxt   = FIRST;
               state_nxt = ROUND;
            end
         end
         ROUND: begin
            rk_idx = rnd;
            // final round skips InvMixColumns
            if (rnd != '0) begin
               st_nxt  = imc;
               rnd_nxt = rnd - RK_IDX_W'(1);
            end else begin
               st_nxt    = ark;
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_data = st;
   assign busy     = (state != IDLE);

`ifdef AES_INV_ROUND_TRACE_EN
   logic upd;
   assign upd = (state == ROUND) || (state == IDLE && in_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_valid <= 1'b0;
         dbg_rnd   <= '0;
         dbg_state <= '0;
      end else begin
         dbg_valid <= upd;
         if (upd) begin
            dbg_rnd   <= 4'((state == IDLE) ? LAST : rnd);
            dbg_state <= st_nxt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Bench for aes_inv_cipher_core: FIPS vectors plus random blocks from a forward-cipher model.
// Trace checks compile in when AES_INV_ROUND_TRACE_EN is defined.
module tb_aes_inv_cipher_core;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
`ifdef AES_INV_ROUND_TRACE_EN
   logic         dbg_valid;
   logic [3:0]   dbg_rnd;
   logic [127:0] dbg_state;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0]   sbox [256];
   logic [127:0] rk_mem [0:10];

   aes_inv_cipher_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef AES_INV_ROUND_TRACE_EN
      ,
      .dbg_valid (dbg_valid),
      .dbg_rnd   (dbg_rnd),
      .dbg_state (dbg_state)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rk_data = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // FIPS hex strings list byte 0 first; the bus puts byte 0 in the LSB
   function automatic logic [127:0] rev(input logic [127:0] h);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127 - 8*i -: 8];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // S-box from the 3-generator walk of GF(2^8) and its inverse walk
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      for (int i = 0; i < 255; i++) begin
         p = p ^ xt(p);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
               ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end
      sbox[0] = 8'h63;
   endtask

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            t[7:0] = t[7:0] ^ rc;
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int k = 0; k < 11; k++)
         rk_mem[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk_mem[0][8*i +: 8];
      for (int n = 1; n <= 10; n++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4*c + r] = t[4*((c + r) % 4) + r];
         if (n < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[n][8*i +: 8];
      end
      for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
      return o;
   endfunction

   // returns at the negedge before the accepting edge
   task automatic wait_accept(output int acc);
      int n;
      n = 0;
      while (!(in_ready && in_valid) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept", in_ready, 1);
      chk("rk_idx_idle", rk_idx, 10);
      acc = cyc;
   endtask

   task automatic collect(input logic [127:0] ct, input logic [127:0] exp,
                          input string tag, input bit hold,
                          input logic [127:0] nxt);
      bit seen;
      int pulses;
      seen = 0;
      pulses = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (hold) in_data = nxt;
            else in_valid = 1'b0;
         end
         if (k <= 10) begin
            chk({tag, "_rk_idx"}, rk_idx, 10 - k);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_early_valid"}, out_valid, 0);
         end
`ifdef AES_INV_ROUND_TRACE_EN
         if (dbg_valid) begin
            pulses++;
            chk({tag, "_dbg_rnd"}, dbg_rnd, 11 - k);
            if (k == 1) chk({tag, "_dbg_first"}, dbg_state, ct ^ rk_mem[10]);
            if (k == 11) chk({tag, "_dbg_last"}, dbg_state, exp);
         end
`endif
         if (out_valid) begin
            seen = 1;
            chk({tag, "_latency"}, k, 11);
            chk({tag, "_data"}, out_data, exp);
         end
      end
      if (!seen) chk({tag, "_timeout"}, out_valid, 1);
`ifdef AES_INV_ROUND_TRACE_EN
      chk({tag, "_dbg_pulses"}, pulses, 11);
`endif
   endtask

   task automatic run(input logic [127:0] ct, input logic [127:0] pt,
                      input string tag);
      int a;
      @(negedge clk);
      in_data  = ct;
      in_valid = 1'b1;
      wait_accept(a);
      collect(ct, pt, tag, 0, '0);
   endtask

   initial begin
      logic [127:0] c1_key, c1_ct, c1_pt;
      logic [127:0] b_key, b_ct, b_pt;
      logic [127:0] pt1, pt2, ct1, ct2;
      int a1, a2, n;

      c1_key = rev(128'h000102030405060708090a0b0c0d0e0f);
      c1_ct  = rev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      c1_pt  = rev(128'h00112233445566778899aabbccddeeff);
      b_key  = rev(128'h2b7e151628aed2a6abf7158809cf4f3c);
      b_ct   = rev(128'h3925841d02dc09fbdc118597196a0b32);
      b_pt   = rev(128'h3243f6a8885a308d313198a2e0370734);

      build_sbox();
      load_key(c1_key);
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rk_idx", rk_idx, 10);
      chk("rst_out_data", out_data, 0);
`ifdef AES_INV_ROUND_TRACE_EN
      chk("rst_dbg_valid", dbg_valid, 0);
      chk("rst_dbg_state", dbg_state, 0);
`endif
      rst = 1'b0;

      chk("c1_in_bus", c1_ct, 128'h5ac5b47080b7cdd830047b6ad8e0c469);
      run(c1_ct, c1_pt, "c1");
      chk("c1_bus_value", out_data, 128'hffeeddccbbaa99887766554433221100);

      @(negedge clk);
      load_key(b_key);
      run(b_ct, b_pt, "appb");

      // backpressure: hold DONE for 20 cycles with a stray in_valid pulse
      @(negedge clk);
      out_ready = 1'b0;
      in_data   = b_ct;
      in_valid  = 1'b1;
      wait_accept(a1);
      collect(b_ct, b_pt, "bp", 0, '0);
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         in_valid = (j == 5);
         in_data  = rnd128();
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, b_pt);
         chk("bp_in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_idle_ready", in_ready, 1);
      chk("bp_idle_valid", out_valid, 0);
      chk("bp_idle_busy", busy, 0);
      pt1 = rnd128();
      run(encrypt(pt1), pt1, "bp_next");

      // back-to-back with in_valid held high
      pt1 = rnd128();
      pt2 = rnd128();
      ct1 = encrypt(pt1);
      ct2 = encrypt(pt2);
      @(negedge clk);
      in_data  = ct1;
      in_valid = 1'b1;
      wait_accept(a1);
      collect(ct1, pt1, "b2b1", 1, ct2);
      wait_accept(a2);
      chk("b2b_interval", a2 - a1, 12);
      collect(ct2, pt2, "b2b2", 0, '0);

      // reset in the middle of round 5
      @(negedge clk);
      in_data  = rnd128();
      in_valid = 1'b1;
      wait_accept(a1);
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end while (rk_idx != 4'd5 && n < 20);
      chk("mid_reach5", rk_idx, 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_in_ready", in_ready, 1);
      chk("mid_busy", busy, 0);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_rk_idx", rk_idx, 10);
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         if (out_valid) chk("mid_no_output", out_valid, 0);
      end
      load_key(c1_key);
      run(c1_ct, c1_pt, "c1_after_rst");

      // random keys and plaintexts
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         load_key(rnd128());
         pt1 = rnd128();
         run(encrypt(pt1), pt1, "rand");
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_cipher_core.md
Name: aes_inv_cipher_core

Overview:
- Iterative AES-128 decryption datapath. It inverts the forward round transforms: InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
- Accepts one 128-bit ciphertext block per valid/ready handshake and executes one round per clock. Delivers the plaintext on an output valid/ready handshake.
- Round keys come from an external, already-expanded key store that is read combinationally by index.
- Sits downstream of the key-expansion block, mirroring the encryption path.

Parameters:
- NR, 10, number of cipher rounds. Fixed for AES-128; other values are unsupported.
- RK_IDX_W, 4, width of the round-key index port.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext present
- in_ready  out  1  core can accept a block
- in_data  in  128  ciphertext block
- rk_idx  out  RK_IDX_W  round-key index requested, 0..10
- rk_data  in  128  round key for rk_idx, valid in the same cycle (combinational store)
- out_valid  out  1  plaintext present
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext block
- busy  out  1  high in ROUND or DONE

Behaviour:
- Byte mapping, used on every 128-bit bus and internally:
  - state byte (row r, col c) = bus[8*(4c+r)+7 : 8*(4c+r)]
  - byte 0 is bus[7:0]
- InvShiftRows: out[r][c] = in[r][(c-r) mod 4]. Row 0 is unchanged; rows 1/2/3 rotate right by 1/2/3.
- InvSubBytes:
  - Per-byte FIPS-197 inverse S-box, fully combinational.
  - Implemented as inverse affine transform followed by GF(2^8) inversion, modulus 0x11B, with 0 mapping to 0.
  - Must match the FIPS-197 table for all 256 inputs.
- InvMixColumns: per column, matrix [0e 0b 0d 09] rotated, over GF(2^8) modulus 0x11B.
- FSM states:
  - IDLE
    - in_ready=1, rk_idx=10.
    - On in_valid&&in_ready: st <= in_data ^ rk_data, rnd <= 9, go to ROUND.
  - ROUND
    - rk_idx=rnd.
    - rnd>=1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_data), rnd <= rnd-1.
    - rnd==0: st <= InvSubBytes(InvShiftRows(st)) ^ rk_data, go to DONE.
  - DONE
    - out_valid=1, out_data=st, held stable until out_ready.
    - On out_ready, go to IDLE.
- Outputs by state:
  - in_ready is high only in IDLE. No new block is accepted in DONE, even when out_ready is high.
  - rk_idx outside IDLE and ROUND: drive 0.
  - out_data outside DONE: drive st. It is only meaningful while out_valid is high.
- Latency:
  - Handshake accepted at edge T gives out_valid=1 from cycle T+11 onward: 10 ROUND cycles, then DONE.
  - Minimum initiation interval is 12 cycles: DONE with out_ready=1, then IDLE accepts next cycle.
- Backpressure: out_ready low holds DONE indefinitely. out_data and out_valid are stable, and in_ready stays 0.
- Reset values (rst high at an edge, regardless of state):
  - FSM=IDLE, st=0, rnd=0.
  - out_valid=0, in_ready=1, busy=0, rk_idx=10.
  - Reset mid-round abandons the block with no output.
- in_data and in_valid are ignored outside IDLE.
- rk_data is sampled only on the cycle its index is driven. The key store must not change round-key contents while busy=1; behaviour is undefined if it does.

Optional Feature:
- Macro: AES_INV_ROUND_TRACE_EN.
- Defined:
  - Adds output ports dbg_rnd (4 bits) and dbg_state (128 bits).
  - Registered copies of the round index and state after each update: IDLE accept gives 10; ROUND gives the rnd just applied.
  - dbg_valid (1 bit) pulses high for exactly the cycle following each update, 11 pulses per block.
  - All three ports reset to 0.
- Undefined: the ports do not exist; core behaviour and timing are identical.

Test Plan:
- FIPS-197 C.1 vector. Key store holds the expansion of key 000102030405060708090a0b0c0d0e0f. Drive in_data=128'h5ac5b47080b7cdd830047b6ad8e0c469 (ct 69c4e0d8…c55a, byte 0 in LSB), out_ready=1. Expect out_data=128'hffeeddccbbaa99887766554433221100 with out_valid rising exactly 11 cycles after acceptance.
- FIPS-197 Appendix B vector. Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32. Expect pt 3243f6a8885a308d313198a2e0370734 (byte-reversed on the bus). Check the rk_idx sequence 10,9,…,0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Expect out_data stable, in_ready=0, and an in_valid pulse ignored. Release, then expect IDLE next cycle and the next block accepted.
- Back-to-back: two blocks with in_valid held high and out_ready=1. Expect the second acceptance exactly 12 cycles after the first and both plaintexts correct.
- Reset mid-op: assert rst in ROUND with rnd=5. Expect the next cycle to show in_ready=1, busy=0, out_valid=0, with no output for the abandoned block. A subsequent C.1 block decrypts correctly.
- With AES_INV_ROUND_TRACE_EN defined, C.1 vector: expect 11 dbg_valid pulses. dbg_rnd goes 10→0. The final dbg_state equals out_data, and the dbg_rnd=10 state equals ct^rk[10].
